uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's UART transmitter (Serializer/Parity/FSM top).
- Deserializes a frame on RX_IN: start bit 0, P_Data_Width data bits LSB first, optional parity bit, stop bit 1.
- Oversamples the line with a clock running at P_Prescale × bit rate, using majority-of-3 at mid-bit.
- Delivers parallel data with a single-cycle valid pulse, plus parity and framing error flags.

Parameters:
- P_Data_Width, 8, number of data bits per frame.
- P_Prescale, 8, Clk cycles per bit. Legal values are 8, 16 and 32.

Ports:
- Clk  input  1  oversampling clock at P_Prescale × baud.
- Reset  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line, asynchronous to Clk, idles high.
- Parity_EN  input  1  1 = frame carries a parity bit. Must be stable while Busy is high.
- Parity_TYP  input  1  0 = even parity, 1 = odd parity. Must be stable while Busy is high.
- P_Data  output  P_Data_Width  last correctly received byte. Holds until the next good frame.
- Data_Valid  output  1  one-cycle pulse when a good frame completes.
- Parity_Error  output  1  one-cycle pulse at frame end when the parity bit mismatches.
- Stop_Error  output  1  one-cycle pulse at frame end when the stop bit samples 0.
- Busy  output  1  high from start detection until the end of frame or abort.

Behaviour:
- Reset (Reset=0, asynchronous):
  - P_Data=0, Data_Valid=0, Parity_Error=0, Stop_Error=0, Busy=0.
  - FSM goes to IDLE; all counters = 0.
  - Both synchronizer flops and the previous-sample register = 1.
  - Reset asserted mid-frame aborts the frame with no pulse and no P_Data update.
- Input synchronization: RX_IN passes through a 2-flop synchronizer. Call its output rx_s. All logic below uses rx_s.
- Counters:
  - edge_cnt counts 0..P_Prescale-1 within each bit and wraps to 0 at each bit boundary.
  - bit_cnt counts data bits 0..P_Data_Width-1.
- Sampling:
  - rx_s is captured at edge_cnt = P_Prescale/2-1, P_Prescale/2 and P_Prescale/2+1.
  - The bit value is the majority of the 3 captures, resolved at edge_cnt = P_Prescale/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge (rx_s=0 and previous rx_s=1), go to START with edge_cnt=0 in that cycle; Busy=1 from the next cycle. A line held low without a new 1→0 edge never triggers.
  - START: if the sampled bit is 1, it is a glitch; return to IDLE immediately after the sample. Busy drops, no pulses. If the sample is 0, go to DATA at the bit wrap.
  - DATA: each sampled bit shifts into a shift register at position bit_cnt (LSB first). After bit P_Data_Width-1 wraps, go to PARITY if Parity_EN=1, otherwise STOP.
  - PARITY: compute expected = XOR of the data bits, inverted when Parity_TYP=1. Record a mismatch with the sampled bit.
  - STOP: a sampled 0 records a stop error. At edge_cnt = P_Prescale-1, go to IDLE and, in the next cycle, pulse the flags:
    - If neither error was recorded: Data_Valid=1 and P_Data updates in the same cycle.
    - Otherwise: Data_Valid=0, P_Data is unchanged, and Parity_Error/Stop_Error pulse as recorded. Both may pulse together.
  - Busy falls in the same cycle as the pulses.
- Latency:
  - Let N = 2 + P_Data_Width + Parity_EN.
  - The pulses occur exactly N×P_Prescale cycles after the start-detect cycle.
  - The start-detect cycle itself is 2 cycles after the RX_IN falling edge, because of the synchronizer.
- Back-to-back frames: a start edge is accepted in the cycle the FSM re-enters IDLE. No idle bit is required beyond the stop bit.
- Glitch tolerance: a single-cycle disturbance at any one sample point does not change the decoded bit.

Test Plan:
1. P_Prescale=8, Parity_EN=0, send 0xA5 → Data_Valid pulses once, P_Data=0xA5, both errors 0, pulse 80 cycles after start detect.
2. Parity_EN=1, Parity_TYP=0, send 0x37 with parity bit 1 (even parity correct) → Data_Valid, P_Data=0x37. Repeat with parity bit 0 → Parity_Error pulse, no Data_Valid, P_Data stays 0x37.
3. Send 0x5A with stop bit 0 → Stop_Error pulse, no Data_Valid, P_Data unchanged. Then hold the line low for 20 bits → no further activity until a new 1→0 edge.
4. 2-cycle low glitch on an idle line → START aborts, Busy returns to 0, no pulses. A 1-cycle flip at the middle sample of data bit 3 of 0x0F → 0x0F is still received.
5. Two frames back-to-back with no idle gap (0x01 then 0xFF, Parity_TYP=1, correct odd parity) → two Data_Valid pulses, P_Data=0x01 then 0xFF.
6. Assert Reset during data bit 4 → all outputs return to 0 asynchronously, Busy=0. After release, the next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled bit timing with
// majority-of-3 mid-bit sampling, optional even/odd parity check, stop-bit
// check, and single-cycle result pulses at frame end.
module uart_rx #(
    parameter int unsigned P_Data_Width = 8,
    parameter int unsigned P_Prescale   = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    RX_IN,
    input  logic                    Parity_EN,
    input  logic                    Parity_TYP,
    output logic [P_Data_Width-1:0] P_Data,
    output logic                    Data_Valid,
    output logic                    Parity_Error,
    output logic                    Stop_Error,
    output logic                    Busy
);

    localparam int unsigned CW = (P_Prescale > 1) ? $clog2(P_Prescale) : 1;
    localparam int unsigned BW = (P_Data_Width > 1) ? $clog2(P_Data_Width) : 1;

    // Sample points straddle mid-bit; the decision is taken on the last one.
    localparam logic [CW-1:0] CNT_S0   = CW'(P_Prescale / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(P_Prescale / 2);
    localparam logic [CW-1:0] CNT_S2   = CW'(P_Prescale / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(P_Prescale - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(P_Data_Width - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected parity bit: XOR of data, inverted for odd parity.
    function automatic logic parity_of(input logic [P_Data_Width-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic                    sync1_q;
    logic                    sync2_q;
    logic                    prev_q;
    logic                    rx_s;
    logic [1:0]              samp_q;
    state_t                  state_q;
    logic [CW-1:0]           edge_cnt_q;
    logic [CW-1:0]           edge_cnt_d;
    logic [BW-1:0]           bit_cnt_q;
    logic [P_Data_Width-1:0] shift_q;
    logic                    par_err_q;
    logic                    stop_err_q;
    logic [P_Data_Width-1:0] p_data_q;
    logic                    data_valid_q;
    logic                    parity_error_q;
    logic                    stop_error_q;
    logic                    busy_q;

    logic                    fall_s;
    logic                    at_res_s;
    logic                    at_last_s;
    logic                    bit_val_s;
    logic                    exp_par_s;

    assign rx_s         = sync2_q;
    assign P_Data       = p_data_q;
    assign Data_Valid   = data_valid_q;
    assign Parity_Error = parity_error_q;
    assign Stop_Error   = stop_error_q;
    assign Busy         = busy_q;

    // Bring RX_IN into the clock domain and remember the previous synced value for edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            sync2_q <= sync1_q;
            prev_q  <= rx_s;
        end
    end

    // Bit-timing decodes, majority vote and expected parity.
    always_comb begin
        fall_s     = 1'b0;
        at_res_s   = 1'b0;
        at_last_s  = 1'b0;
        bit_val_s  = 1'b0;
        exp_par_s  = 1'b0;
        edge_cnt_d = {CW{1'b0}};
        fall_s     = (~rx_s) & prev_q;
        at_res_s   = (edge_cnt_q == CNT_S2);
        at_last_s  = (edge_cnt_q == CNT_LAST);
        bit_val_s  = maj3(samp_q[0], samp_q[1], rx_s);
        exp_par_s  = parity_of(shift_q, Parity_TYP);
        if (at_last_s) begin
            edge_cnt_d = {CW{1'b0}};
        end else begin
            edge_cnt_d = edge_cnt_q + CW'(1);
        end
    end

    // Capture the first two of the three mid-bit samples; the third is taken live.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            samp_q <= 2'b11;
        end else if (edge_cnt_q == CNT_S0) begin
            samp_q[0] <= rx_s;
        end else if (edge_cnt_q == CNT_S1) begin
            samp_q[1] <= rx_s;
        end else begin
            samp_q <= samp_q;
        end
    end

    // Frame FSM with counters, error recording and registered result pulses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q        <= ST_IDLE;
            edge_cnt_q     <= {CW{1'b0}};
            bit_cnt_q      <= {BW{1'b0}};
            shift_q        <= {P_Data_Width{1'b0}};
            par_err_q      <= 1'b0;
            stop_err_q     <= 1'b0;
            p_data_q       <= {P_Data_Width{1'b0}};
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    edge_cnt_q <= {CW{1'b0}};
                    bit_cnt_q  <= {BW{1'b0}};
                    if (fall_s) begin
                        // The detect cycle is count 0 of the start bit.
                        state_q    <= ST_START;
                        edge_cnt_q <= CW'(1);
                        busy_q     <= 1'b1;
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                    end
                end
                ST_START: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_res_s && bit_val_s) begin
                        // Start bit did not hold low: treat as a glitch.
                        state_q    <= ST_IDLE;
                        edge_cnt_q <= {CW{1'b0}};
                        busy_q     <= 1'b0;
                    end else if (at_last_s) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_res_s) begin
                        // LSB arrives first, so shifting right lands it at bit 0.
                        shift_q <= {bit_val_s, shift_q[P_Data_Width-1:1]};
                    end
                    if (at_last_s) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= {BW{1'b0}};
                            state_q   <= Parity_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_res_s) begin
                        par_err_q <= (bit_val_s != exp_par_s);
                    end
                    if (at_last_s) begin
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_res_s) begin
                        stop_err_q <= ~bit_val_s;
                    end
                    if (at_last_s) begin
                        state_q    <= ST_IDLE;
                        edge_cnt_q <= {CW{1'b0}};
                        busy_q     <= 1'b0;
                        if (!par_err_q && !stop_err_q) begin
                            data_valid_q <= 1'b1;
                            p_data_q     <= shift_q;
                        end else begin
                            parity_error_q <= par_err_q;
                            stop_error_q   <= stop_err_q;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    edge_cnt_q <= {CW{1'b0}};
                    bit_cnt_q  <= {BW{1'b0}};
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule
